// File: rtl/gpio_input_debouncer_if.sv
// Signal bundle between the raw GPIO pins, the debouncer and its consumers.
//   rawInputs        asynchronous pin levels (into the debouncer)
//   debouncedInputs  filtered levels (to the GPIO slave's externalInputs)
//   risingEdges      one-cycle pulse per bit on an accepted 0->1 change
//   fallingEdges     one-cycle pulse per bit on an accepted 1->0 change
//   anyChange        one-cycle pulse when any edge bit is set
// Modports: slave = debouncer view, master = pin driver / consumer view.
interface gpio_input_debouncer_if #(
  parameter int unsigned nrOfInputs = 8
) ();
  logic [nrOfInputs-1:0] rawInputs;
  logic [nrOfInputs-1:0] debouncedInputs;
  logic [nrOfInputs-1:0] risingEdges;
  logic [nrOfInputs-1:0] fallingEdges;
  logic                  anyChange;

  modport slave (
    input  rawInputs,
    output debouncedInputs,
    output risingEdges,
    output fallingEdges,
    output anyChange
  );

  modport master (
    output rawInputs,
    input  debouncedInputs,
    input  risingEdges,
    input  fallingEdges,
    input  anyChange
  );
endinterface

// File: rtl/gpio_input_debouncer.sv
// Per-bit two-flop synchroniser plus stability filter for GPIO inputs.
// A new level is accepted only after it has been seen on the synchronised
// input for stableCycles consecutive cycles; acceptance produces a
// one-cycle rising/falling pulse and an anyChange pulse.
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous, active-high; clears all state
//   bus    gpio_input_debouncer_if.slave (rawInputs in, filtered outputs)
module gpio_input_debouncer #(
  parameter int unsigned nrOfInputs   = 8,
  parameter int unsigned stableCycles = 1000,
  parameter int unsigned counterWidth = 16
) (
  input logic                   clock,
  input logic                   reset,
  gpio_input_debouncer_if.slave bus
);

  localparam logic [counterWidth-1:0] CntLast = counterWidth'(stableCycles - 1);

  logic [nrOfInputs-1:0]   sync1_q, sync2_q;
  logic [nrOfInputs-1:0]   deb_q, deb_d;
  logic [nrOfInputs-1:0]   rise_q, rise_d;
  logic [nrOfInputs-1:0]   fall_q, fall_d;
  logic                    any_q, any_d;
  logic [counterWidth-1:0] cnt_q [nrOfInputs];
  logic [counterWidth-1:0] cnt_d [nrOfInputs];

  always_comb begin
    deb_d  = deb_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < int'(nrOfInputs); i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        // Input agrees with accepted level: any partial count was a glitch.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        deb_d[i]  = sync2_q[i];
        cnt_d[i]  = '0;
        rise_d[i] = sync2_q[i];
        fall_d[i] = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    any_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < int'(nrOfInputs); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= bus.rawInputs;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
      for (int i = 0; i < int'(nrOfInputs); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.debouncedInputs = deb_q;
  assign bus.risingEdges     = rise_q;
  assign bus.fallingEdges    = fall_q;
  assign bus.anyChange       = any_q;

endmodule
